// File: rtl/conv_seq_sched.sv
`default_nettype none
// ============================================================================
// Module   : conv_seq_sched
// Function : Address/MAC sequencer for the 1-D convolution datapath.
// Revision : 1.0 - initial release
// ============================================================================
module conv_seq_sched #(
  parameter int XN  = 256,
  parameter int FN  = 32,
  parameter int XAW = 8,
  parameter int FAW = 5,
  parameter int YW  = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           x_full,
  input  logic           f_full,
  output logic           rd_en,
  output logic [XAW-1:0] x_rd_addr,
  output logic [FAW-1:0] f_rd_addr,
  output logic           acc_clr,
  output logic           acc_en,
  output logic           y_valid,
  input  logic           y_ready,
  output logic [YW-1:0]  y_index,
  output logic           frame_done,
  output logic           busy
);

  localparam int             YN     = XN - FN + 1;
  localparam logic [FAW-1:0] K_LAST = FAW'(FN - 1);
  localparam logic [YW-1:0]  Y_LAST = YW'(YN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_FLUSH = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         state, state_nxt;
  logic [FAW-1:0] k, k_nxt;
  logic [XAW-1:0] base, base_nxt;
  logic [YW-1:0]  yidx_nxt;
  logic [XAW-1:0] x_addr_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      k       <= '0;
      base    <= '0;
      y_index <= '0;
    end else begin
      state   <= state_nxt;
      k       <= k_nxt;
      base    <= base_nxt;
      y_index <= yidx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    base_nxt  = base;
    yidx_nxt  = y_index;
    case (state)
      S_IDLE: begin
        if (x_full && f_full) begin
          state_nxt = S_RUN;
          k_nxt     = '0;
          base_nxt  = '0;
          yidx_nxt  = '0;
        end
      end
      S_RUN: begin
        if (k == K_LAST) begin
          state_nxt = S_FLUSH;
        end else begin
          k_nxt = k + 1'b1;
        end
      end
      S_FLUSH: begin
        state_nxt = S_OUT;
      end
      S_OUT: begin
        if (y_ready) begin
          k_nxt = '0;
          if (y_index == Y_LAST) begin
            state_nxt = S_DONE;
            base_nxt  = '0;
            yidx_nxt  = '0;
          end else begin
            state_nxt = S_RUN;
            base_nxt  = base + 1'b1;
            yidx_nxt  = y_index + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign x_addr_nxt = base_nxt + XAW'(k_nxt);

  // Outputs are registered from the next state so each strobe lines up with
  // the cycle the sequencer actually occupies that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en      <= 1'b0;
      x_rd_addr  <= '0;
      f_rd_addr  <= '0;
      acc_clr    <= 1'b0;
      acc_en     <= 1'b0;
      y_valid    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      rd_en      <= (state_nxt == S_RUN);
      acc_clr    <= (state_nxt == S_RUN) && (k_nxt == '0);
      acc_en     <= rd_en;
      y_valid    <= (state_nxt == S_OUT);
      frame_done <= (state_nxt == S_DONE);
      if (state_nxt == S_RUN) begin
        x_rd_addr <= x_addr_nxt;
        f_rd_addr <= k_nxt;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_conv_seq_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_seq_sched
// Function : Directed self-checking bench for conv_seq_sched (two configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_seq_sched;

  logic clk;
  logic reset;
  logic x_full, f_full, y_ready;
  logic x_full1, f_full1;

  logic       d0_rd_en, d0_acc_clr, d0_acc_en, d0_y_valid, d0_frame_done, d0_busy;
  logic [7:0] d0_x_rd_addr;
  logic [4:0] d0_f_rd_addr;
  logic [7:0] d0_y_index;

  logic       d1_rd_en, d1_acc_clr, d1_acc_en, d1_y_valid, d1_frame_done, d1_busy;
  logic [2:0] d1_x_rd_addr;
  logic [1:0] d1_f_rd_addr;
  logic [2:0] d1_y_index;

  logic [5:0] d0_ctl, d1_ctl;
  assign d0_ctl = {d0_rd_en, d0_acc_clr, d0_acc_en, d0_y_valid, d0_frame_done, d0_busy};
  assign d1_ctl = {d1_rd_en, d1_acc_clr, d1_acc_en, d1_y_valid, d1_frame_done, d1_busy};

  int checks = 0;
  int errors = 0;
  int c;

  conv_seq_sched u_d0 (
    .clk(clk), .reset(reset), .x_full(x_full), .f_full(f_full),
    .rd_en(d0_rd_en), .x_rd_addr(d0_x_rd_addr), .f_rd_addr(d0_f_rd_addr),
    .acc_clr(d0_acc_clr), .acc_en(d0_acc_en), .y_valid(d0_y_valid),
    .y_ready(y_ready), .y_index(d0_y_index), .frame_done(d0_frame_done),
    .busy(d0_busy)
  );

  conv_seq_sched #(.XN(8), .FN(4), .XAW(3), .FAW(2), .YW(3)) u_d1 (
    .clk(clk), .reset(reset), .x_full(x_full1), .f_full(f_full1),
    .rd_en(d1_rd_en), .x_rd_addr(d1_x_rd_addr), .f_rd_addr(d1_f_rd_addr),
    .acc_clr(d1_acc_clr), .acc_en(d1_acc_en), .y_valid(d1_y_valid),
    .y_ready(1'b1), .y_index(d1_y_index), .frame_done(d1_frame_done),
    .busy(d1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int cyc, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs for cycle cyc of a frame with y_ready held high.
  // Ctrl bit order: rd_en, acc_clr, acc_en, y_valid, frame_done, busy.
  task automatic frame_chk(input string tag, input int cyc, input int fn, input int yn,
                           input logic [5:0] ctl, input int xa, input int fa, input int yi);
    int per, last, w, p, ex, ef;
    logic [5:0] ec;
    per  = fn + 2;
    last = yn * per;
    if (cyc <= last) begin
      w = (cyc - 1) / per;
      p = (cyc - 1) % per;
      if (p < fn) begin
        ec = {1'b1, p == 0, p != 0, 1'b0, 1'b0, 1'b1};
        ex = w + p;
        ef = p;
      end else if (p == fn) begin
        ec = 6'b001001;
        ex = w + fn - 1;
        ef = fn - 1;
      end else begin
        ec = 6'b000101;
        ex = w + fn - 1;
        ef = fn - 1;
      end
      chk($sformatf("%s_ctl", tag), cyc, {42'd0, ctl}, {42'd0, ec});
      chk($sformatf("%s_addr", tag), cyc, {16'(xa), 16'(fa), 16'(yi)}, {16'(ex), 16'(ef), 16'(w)});
    end else if (cyc == last + 1) begin
      chk($sformatf("%s_done", tag), cyc, {42'd0, ctl}, {42'd0, 6'b000011});
    end else begin
      chk($sformatf("%s_idle", tag), cyc, {42'd0, ctl}, {42'd0, 6'b000000});
    end
  endtask

  initial begin
    reset   = 1'b1;
    x_full  = 1'b1;
    f_full  = 1'b1;
    y_ready = 1'b1;
    x_full1 = 1'b0;
    f_full1 = 1'b0;

    // Reset held with both flags high
    repeat (3) @(negedge clk);
    chk("rst_ctl0", 0, {42'd0, d0_ctl}, 48'd0);
    chk("rst_addr0", 0, {16'(d0_x_rd_addr), 16'(d0_f_rd_addr), 16'(d0_y_index)}, 48'd0);
    chk("rst_ctl1", 0, {42'd0, d1_ctl}, 48'd0);
    chk("rst_addr1", 0, {16'(d1_x_rd_addr), 16'(d1_f_rd_addr), 16'(d1_y_index)}, 48'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_release_run", 1, {42'd0, d0_ctl}, {42'd0, 6'b110001});

    // Partial fill: only x_full high
    reset  = 1'b1;
    f_full = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      chk("partial_idle", i, {46'd0, d0_rd_en, d0_busy}, 48'd0);
    end
    f_full = 1'b1;

    // Full frame 1, y_ready high throughout
    @(negedge clk);
    c = 1;
    frame_chk("f1", c, 32, 225, d0_ctl, d0_x_rd_addr, d0_f_rd_addr, d0_y_index);
    x_full = 1'b0;
    f_full = 1'b0;
    for (c = 2; c <= 7652; c++) begin
      @(negedge clk);
      frame_chk("f1", c, 32, 225, d0_ctl, d0_x_rd_addr, d0_f_rd_addr, d0_y_index);
    end

    // Frame 2: backpressure at window 3, then reset mid-RUN of window 7
    x_full = 1'b1;
    f_full = 1'b1;
    @(negedge clk);
    c = 1;
    frame_chk("f2", c, 32, 225, d0_ctl, d0_x_rd_addr, d0_f_rd_addr, d0_y_index);
    x_full = 1'b0;
    f_full = 1'b0;
    for (c = 2; c <= 135; c++) begin
      @(negedge clk);
      frame_chk("f2", c, 32, 225, d0_ctl, d0_x_rd_addr, d0_f_rd_addr, d0_y_index);
      if (c == 130) y_ready = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ctl", 136 + i, {42'd0, d0_ctl}, {42'd0, 6'b000101});
      chk("bp_addr", 136 + i, {16'(d0_x_rd_addr), 16'(d0_f_rd_addr), 16'(d0_y_index)},
          {16'd34, 16'd31, 16'd3});
    end
    y_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_ctl", 141, {42'd0, d0_ctl}, {42'd0, 6'b110001});
    chk("bp_resume_addr", 141, {16'(d0_x_rd_addr), 16'(d0_f_rd_addr), 16'(d0_y_index)},
        {16'd4, 16'd0, 16'd4});
    repeat (112) @(negedge clk);
    chk("w7_k10_addr", 253, {16'(d0_x_rd_addr), 16'(d0_f_rd_addr), 16'(d0_y_index)},
        {16'd17, 16'd10, 16'd7});
    x_full = 1'b1;
    f_full = 1'b1;
    reset  = 1'b1;
    @(negedge clk);
    chk("midrun_rst_ctl", 254, {42'd0, d0_ctl}, 48'd0);
    chk("midrun_rst_yidx", 254, {40'd0, d0_y_index}, 48'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("restart_ctl", 255, {42'd0, d0_ctl}, {42'd0, 6'b110001});
    chk("restart_addr", 255, {16'(d0_x_rd_addr), 16'(d0_f_rd_addr), 16'(d0_y_index)}, 48'd0);
    x_full = 1'b0;
    f_full = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Small configuration XN=8, FN=4: two back-to-back frames
    for (int fr = 0; fr < 2; fr++) begin
      x_full1 = 1'b1;
      f_full1 = 1'b1;
      @(negedge clk);
      c = 1;
      frame_chk("small", c, 4, 5, d1_ctl, d1_x_rd_addr, d1_f_rd_addr, d1_y_index);
      x_full1 = 1'b0;
      f_full1 = 1'b0;
      for (c = 2; c <= 32; c++) begin
        @(negedge clk);
        frame_chk("small", c, 4, 5, d1_ctl, d1_x_rd_addr, d1_f_rd_addr, d1_y_index);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
